alu_op_sequencer: RTL

Command-side initiator that drives the 5-bit ALU's operand, opcode and flag interface.
- Accepts operation commands on a valid/ready handshake and sequences one or more ALU cycles per command.
- Multi-bit shifts are built by iterating the ALU's single-bit SHL/SHR.
- Multiply is built from SHL + ADD steps.
- Returns a registered result plus flags on a valid/ready response port.
- Sits between the control unit and the combinational ALU.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_sequencer_iter.sv | 34 +++
 rtl/alu_op_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : shared ALU opcodes, command encoding, states, flag indices |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_N = 5;

    localparam logic [3:0] OPC_NOP = 4'b0000;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_AND = 4'b1010;
    localparam logic [3:0] OPC_XOR = 4'b0001;
    localparam logic [3:0] OPC_SHL = 4'b1000;
    localparam logic [3:0] OPC_SHR = 4'b1001;

    // Bit positions inside the 4-bit {N,Z,C,O} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        CMD_ADD = 3'b000,
        CMD_AND = 3'b001,
        CMD_XOR = 3'b010,
        CMD_SHL = 3'b011,
        CMD_SHR = 3'b100,
        CMD_MUL = 3'b101
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_MUL_SHL = 3'd3,
        ST_MUL_ADD = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_iter_counter : loadable down-counter, last asserted at zero      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_iter_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_op_sequencer : sequences multi-cycle ops onto a 1-step ALU       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int         N       = ALU_N,
    parameter logic [3:0] ALU_ADD = OPC_ADD,
    parameter logic [3:0] ALU_AND = OPC_AND,
    parameter logic [3:0] ALU_XOR = OPC_XOR,
    parameter logic [3:0] ALU_SHL = OPC_SHL,
    parameter logic [3:0] ALU_SHR = OPC_SHR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_s,
    input  logic [N-1:0] alu_out,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic         busy
);

    localparam int           CW    = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0] C_NV  = N[N-1:0];

    state_e          r_state;
    state_e          w_next;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    r_opb;
    logic [N-1:0]    r_b;
    logic [2:0]      r_op;
    logic            r_sc;
    logic            r_so;
    logic [N-1:0]    r_rsp_data;
    logic [3:0]      r_rsp_flags;
    logic            r_rsp_err;

    logic [3:0]      w_alu_s;
    logic            w_ctr_load;
    logic [CW-1:0]   w_ctr_val;
    logic            w_ctr_dec;
    logic [CW-1:0]   w_cnt;
    logic            w_last;
    logic [CW-1:0]   w_shift_load;
    logic            w_alu_c;

    // Shift counts saturate at N; the counter holds (iterations - 1)
    assign w_shift_load = (cmd_b >= C_NV) ? CW'(N - 1) : CW'(cmd_b - 1'b1);
    assign w_alu_c      = alu_flags[FLAG_C];

    seq_iter_counter #(
        .W (CW)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_ctr_load),
        .load_val (w_ctr_val),
        .dec      (w_ctr_dec),
        .count    (w_cnt),
        .last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_alu_s    = OPC_NOP;
        w_ctr_load = 1'b0;
        w_ctr_val  = '0;
        w_ctr_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        CMD_ADD, CMD_AND, CMD_XOR: w_next = ST_EXEC;
                        CMD_SHL, CMD_SHR: begin
                            if (cmd_b == '0) begin
                                w_next = ST_RESP;
                            end else begin
                                w_next     = ST_SHIFT;
                                w_ctr_load = 1'b1;
                                w_ctr_val  = w_shift_load;
                            end
                        end
                        CMD_MUL: begin
                            w_next     = ST_MUL_SHL;
                            w_ctr_load = 1'b1;
                            w_ctr_val  = CW'(N - 1);
                        end
                        default: w_next = ST_RESP;
                    endcase
                end
            end
            ST_EXEC: begin
                case (r_op)
                    CMD_AND: w_alu_s = ALU_AND;
                    CMD_XOR: w_alu_s = ALU_XOR;
                    default: w_alu_s = ALU_ADD;
                endcase
                w_next = ST_RESP;
            end
            ST_SHIFT: begin
                w_alu_s = (r_op == CMD_SHL) ? ALU_SHL : ALU_SHR;
                if (w_last) begin
                    w_next = ST_RESP;
                end else begin
                    w_ctr_dec = 1'b1;
                end
            end
            ST_MUL_SHL: begin
                w_alu_s = ALU_SHL;
                if (r_b[w_cnt]) begin
                    w_next = ST_MUL_ADD;
                end else if (w_last) begin
                    w_next = ST_RESP;
                end else begin
                    w_ctr_dec = 1'b1;
                end
            end
            ST_MUL_ADD: begin
                w_alu_s = ALU_ADD;
                if (w_last) begin
                    w_next = ST_RESP;
                end else begin
                    w_ctr_dec = 1'b1;
                    w_next    = ST_MUL_SHL;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_acc/r_opb feed the ALU directly, so they only move when a new ALU
    // step needs them and otherwise hold the last driven operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_opb       <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_sc        <= 1'b0;
            r_so        <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_b       <= cmd_b;
                        r_rsp_err <= 1'b0;
                        case (cmd_op)
                            CMD_ADD, CMD_AND, CMD_XOR: begin
                                r_acc <= cmd_a;
                                r_opb <= cmd_b;
                            end
                            CMD_SHL, CMD_SHR: begin
                                if (cmd_b == '0) begin
                                    r_rsp_data  <= cmd_a;
                                    r_rsp_flags <= {cmd_a[N-1], (cmd_a == '0), 1'b0, 1'b0};
                                end else begin
                                    r_acc <= cmd_a;
                                    r_opb <= '0;
                                end
                            end
                            CMD_MUL: begin
                                r_acc <= '0;
                                r_opb <= cmd_a;
                                r_sc  <= 1'b0;
                                r_so  <= 1'b0;
                            end
                            default: begin
                                r_rsp_data  <= '0;
                                r_rsp_flags <= '0;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_flags <= alu_flags;
                end
                ST_SHIFT: begin
                    r_acc <= alu_out;
                    if (w_last) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_flags <= alu_flags;
                    end
                end
                ST_MUL_SHL: begin
                    r_acc <= alu_out;
                    r_so  <= r_so | r_acc[N-1];
                    if (!r_b[w_cnt] && w_last) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_flags <= {alu_out[N-1], (alu_out == '0), r_sc, r_so | r_acc[N-1]};
                    end
                end
                ST_MUL_ADD: begin
                    r_acc <= alu_out;
                    r_sc  <= r_sc | w_alu_c;
                    r_so  <= r_so | w_alu_c;
                    if (w_last) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_flags <= {alu_out[N-1], (alu_out == '0), r_sc | w_alu_c, r_so | w_alu_c};
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;
    assign alu_a     = r_acc;
    assign alu_b     = r_opb;
    assign alu_s     = w_alu_s;

endmodule
`default_nettype wire
